// File: rtl/fetch_stage.sv
// Instruction fetch stage.
// Owns the PC and drives a synchronous ROM with a 1-cycle read latency.
// The ROM word that arrives this cycle belongs to cur_pc_reg, which is the
// address presented on the previous cycle. That word is offered to decode
// over a valid/ready handshake. While decode stalls, the same address is
// presented again, so the ROM output stays stable without a skid buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    output logic [31:0] fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FAULT = 2'd2;

    logic [1:0]  state_reg, state_next;
    logic [31:0] cur_pc_reg, cur_pc_next;
    logic        cur_valid_reg, cur_valid_next;
    logic        cur_fault_reg, cur_fault_next;
    logic [31:0] fetch_count_reg;

    logic        fire;
    logic        redirect_misaligned;
    logic [31:0] redirect_target;
    logic        in_fault;

    assign redirect_misaligned = redirect_valid & (|redirect_pc[1:0]);
    assign redirect_target     = {redirect_pc[31:2], 2'b00};
    assign in_fault            = (state_reg == ST_FAULT);

    // A redirect squashes the word that is in flight in the same cycle.
    assign out_valid   = cur_valid_reg & ~redirect_valid;
    assign fire        = out_valid & out_ready;
    assign out_pc      = cur_pc_reg;
    assign out_instr   = cur_fault_reg ? NOP_INSTR : rom_data;
    assign out_fault   = cur_fault_reg;
    assign fetch_count = fetch_count_reg;

    // ROM address select. A redirect has top priority. A stalled or faulted
    // word re-reads its own address. An accepted word advances to the next
    // sequential address.
    always_comb begin
        rom_addr = cur_pc_reg;
        if (redirect_valid) begin
            rom_addr = redirect_target;
        end else if (in_fault) begin
            rom_addr = cur_pc_reg;
        end else if (cur_valid_reg && fire) begin
            rom_addr = cur_pc_reg + 32'd4;
        end
    end

    // Next PC, valid, fault flag and FSM state.
    always_comb begin
        cur_pc_next    = rom_addr;
        cur_valid_next = fetch_en;
        cur_fault_next = 1'b0;
        state_next     = state_reg;
        if (redirect_valid) begin
            // A misaligned target presents one fault NOP, whatever fetch_en is.
            cur_valid_next = redirect_misaligned ? 1'b1 : fetch_en;
            cur_fault_next = redirect_misaligned;
            if (redirect_misaligned) begin
                state_next = ST_FAULT;
            end else begin
                state_next = fetch_en ? ST_RUN : ST_IDLE;
            end
        end else if (in_fault) begin
            // Hold the fault NOP until decode takes it, then go quiet.
            cur_valid_next = cur_valid_reg & ~fire;
            cur_fault_next = cur_fault_reg & ~fire;
        end else begin
            if (cur_valid_reg && !fire) begin
                cur_valid_next = 1'b1;
            end
            case (state_reg)
                ST_IDLE: if (fetch_en) state_next = ST_RUN;
                ST_RUN:  if (!fetch_en && (!cur_valid_reg || fire)) state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cur_pc_reg    <= RESET_PC;
            cur_valid_reg <= 1'b0;
            cur_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cur_pc_reg    <= cur_pc_next;
            cur_valid_reg <= cur_valid_next;
            cur_fault_reg <= cur_fault_next;
        end
    end

    // Accepted-instruction counter. Fault NOPs are counted as well.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_reg <= 32'd0;
        end else if (fire) begin
            fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

endmodule
